apb_adc_multi: RTL and testbench
================================

Name: apb_adc_multi

Overview:
- APB slave that captures samples from NUM_CH parallel ADC channels into per-channel holding registers.
- Each channel has a valid flag and a sticky overrun flag, plus a per-channel enable in a control register.
- Successor to the single-channel APB ADC reader: it adds addressing, multiple channels, configurable width, read-to-clear semantics and an optional averaging mode.
- Sits on the peripheral APB bus between the ADC front-ends and the CPU/PID firmware.

Parameters:
- NUM_CH, 4: number of ADC channels; legal range 1..8.
- ADC_W, 12: sample width in bits; legal range 1..16.
- AVG_LOG2, 2: log2 of the number of samples averaged per published value; only used with ADC_AVG_EN.

Ports:
- PCLK  in  1  APB clock; the single clock of the block.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB write (1) / read (0).
- PADDR  in  8  APB byte address; bits [1:0] ignored.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  tied to 1; no wait states.
- PSLVERR  out  1  error response for an unmapped access.
- ADC_DATA  in  NUM_CH*ADC_W  packed samples; channel ch occupies bits [ch*ADC_W +: ADC_W].
- ADC_VALID  in  NUM_CH  one-cycle sample strobe per channel, synchronous to PCLK.

Behaviour:
- Reset (PRESETn low, asynchronous): all data registers 0; valid=0; overrun=0; CTRL enables all 1; averaging accumulators and counters 0. PRDATA=0, PSLVERR=0.
- Access phase: PSEL & PENABLE. Completes in that cycle because PREADY=1.
- Register map:
  - 0x00+4*ch, ch<NUM_CH: DATA_ch, read-only. [ADC_W-1:0]=sample, [31]=valid_ch, other bits 0.
  - 0x40: STATUS, read-only. [NUM_CH-1:0]=valid, [16+NUM_CH-1:16]=overrun.
  - 0x44: CTRL, read/write. [NUM_CH-1:0]=channel enable; other bits read 0 and writes to them are ignored.
  - 0x48: OVR_CLR, write-1-to-clear overrun bits from PWDATA[NUM_CH-1:0]; reads return 0.
- PRDATA: combinational from the current register state during the access phase. Outside the access phase it is 0. The value returned is the pre-update value of that cycle.
- Unmapped address (including DATA_ch with ch>=NUM_CH), or a write to a read-only register: PSLVERR=1 in the access phase, PRDATA=0, no state change.
- Capture (per channel, every cycle): when ADC_VALID[ch] & en[ch], data_ch <= sample and valid_ch <= 1.
  - If valid_ch was already 1 and DATA_ch is not being read in the same cycle, overrun_ch <= 1.
- Read-to-clear: a read access to DATA_ch clears valid_ch at the end of the cycle.
- Simultaneous read of DATA_ch and capture on ch: the read returns the old sample. The capture wins: valid_ch stays 1 with the new sample, and overrun is not set.
- Simultaneous OVR_CLR write and new overrun on the same channel: the set wins, so overrun stays 1.
- Disabled channel: ADC_VALID is ignored; data, valid and overrun hold their values. Clearing an enable bit does not clear valid.
- Capture latency: sample visible in DATA_ch on the cycle after the ADC_VALID strobe.

Optional Feature:
- Macro: ADC_AVG_EN.
- Defined: each channel has an accumulator of ADC_W+AVG_LOG2 bits and a counter of AVG_LOG2 bits.
  - Every accepted strobe adds the sample to the accumulator.
  - On the 2^AVG_LOG2-th strobe, data_ch <= (acc + sample) >> AVG_LOG2 (truncating), the valid/overrun rules apply, and the accumulator and counter clear.
  - Clearing an enable bit clears that channel's accumulator and counter.
- Undefined: every accepted strobe publishes directly; no accumulator logic is present.

Decomposition:
- Shared package apb_adc_pkg holds:
  - address offsets: DATA_BASE=0x00, STATUS=0x40, CTRL=0x44, OVR_CLR=0x48;
  - valid bit position 31;
  - overrun field base 16.
- One sub-module, adc_chan_capture, is instantiated NUM_CH times in a generate loop.
  - It holds data, valid, overrun and the optional averaging logic.
  - Inputs: strobe, sample, enable, rd_clr, ovr_clr.
- The top level keeps the APB decode, CTRL and the PRDATA mux.

Test Plan:
1. Reset, then read 0x44 -> 0x0000000F. Read 0x40 -> 0. PSLVERR=0.
2. ADC_VALID[2] pulse with ch2 sample 0xABC. Next read of 0x08 -> 0x80000ABC. Second read of 0x08 -> 0x00000ABC (valid cleared).
3. Two ch0 strobes (0x111, then 0x222) with no read between -> read 0x40 shows bit16=1. Write 0x48 with 0x1 -> bit16=0.
4. Ch1 strobe with 0x555 in the same cycle as a read of 0x04 holding 0x80000123 -> PRDATA=0x80000123. Next read -> 0x80000555; overrun bit17 stays 0.
5. Write 0x44 with 0xE, then ch0 strobe 0x7FF -> DATA_0 unchanged. Read 0x10 with NUM_CH=4 -> PSLVERR=1, PRDATA=0.
6. With ADC_AVG_EN and AVG_LOG2=2: ch3 samples 1, 2, 3, 6 -> valid only after the 4th strobe, DATA_3=0x80000003.

Source files
------------

// File: rtl/apb_adc_pkg.sv
// apb_adc_pkg: shared register-map constants and decode types for the
// multi-channel APB ADC capture block (apb_adc_multi).
// No ports; imported by apb_adc_multi and adc_chan_capture.
package apb_adc_pkg;

  localparam logic [7:0] DATA_BASE   = 8'h00;
  localparam logic [7:0] STATUS_OFS  = 8'h40;
  localparam logic [7:0] CTRL_OFS    = 8'h44;
  localparam logic [7:0] OVR_CLR_OFS = 8'h48;

  localparam int VALID_BIT = 31;
  localparam int OVR_BASE  = 16;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_DATA,
    REG_STATUS,
    REG_CTRL,
    REG_OVR_CLR
  } reg_sel_e;

endpackage

// File: rtl/adc_chan_capture.sv
// adc_chan_capture: one ADC channel's holding register with valid and sticky
// overrun flags, plus the optional averaging front end (macro ADC_AVG_EN).
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   strobe_i         one-cycle sample strobe
//   sample_i         ADC sample
//   enable_i         channel enable (strobes ignored while low)
//   rd_clr_i         DATA register of this channel read this cycle
//   ovr_clr_i        write-1-to-clear request for the overrun flag
//   data_o, valid_o, overrun_o   registered channel state
module adc_chan_capture
  import apb_adc_pkg::*;
#(
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             strobe_i,
  input  logic [ADC_W-1:0] sample_i,
  input  logic             enable_i,
  input  logic             rd_clr_i,
  input  logic             ovr_clr_i,
  output logic [ADC_W-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  if (AVG_LOG2 < 1 || AVG_LOG2 > 8) begin : g_bad_avg
    $error("adc_chan_capture: AVG_LOG2 out of range");
  end

  logic             accept;
  logic             publish;
  logic [ADC_W-1:0] pub_val;
  logic [ADC_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  assign accept = strobe_i & enable_i;

`ifdef ADC_AVG_EN
  localparam int ACC_W = ADC_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;

  // acc_q holds at most 2^AVG_LOG2-1 samples, so the final sum still fits ACC_W
  assign sum     = acc_q + ACC_W'(sample_i);
  assign publish = accept & (&cnt_q);
  assign pub_val = sum[ACC_W-1:AVG_LOG2];

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (!enable_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = (&cnt_q) ? '0 : sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
`else
  assign publish = accept;
  assign pub_val = sample_i;
`endif

  // A capture beats a same-cycle read-to-clear, and a new overrun beats W1C.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (publish) begin
      data_d  = pub_val;
      valid_d = 1'b1;
      if (valid_q && !rd_clr_i) ovr_d = 1'b1;
      else if (ovr_clr_i)       ovr_d = 1'b0;
    end else begin
      if (rd_clr_i)  valid_d = 1'b0;
      if (ovr_clr_i) ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/apb_adc_multi.sv
// apb_adc_multi: APB slave capturing NUM_CH parallel ADC channels into
// per-channel holding registers with valid / sticky overrun flags.
// Optional averaging per channel when ADC_AVG_EN is defined.
// Ports:
//   PCLK, PRESETn                  clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY, PSLVERR   APB
//   ADC_DATA   packed samples, channel ch at [ch*ADC_W +: ADC_W]
//   ADC_VALID  per-channel one-cycle sample strobe
// Map: 0x00+4*ch DATA_ch (RO, read clears valid), 0x40 STATUS (RO),
//      0x44 CTRL enables (RW), 0x48 OVR_CLR (W1C).
module apb_adc_multi
  import apb_adc_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [7:0]              PADDR,
  input  logic [31:0]             PWDATA,
  output logic [31:0]             PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [NUM_CH*ADC_W-1:0] ADC_DATA,
  input  logic [NUM_CH-1:0]       ADC_VALID
);

  if (NUM_CH < 1 || NUM_CH > 8 || ADC_W < 1 || ADC_W > 16) begin : g_bad_param
    $error("apb_adc_multi: NUM_CH or ADC_W out of range");
  end

  logic              access;
  logic              err;
  logic [5:0]        data_idx;
  reg_sel_e          sel;
  logic [NUM_CH-1:0] ctrl_q, ctrl_d;
  logic [NUM_CH-1:0] rd_clr;
  logic [NUM_CH-1:0] ovr_clr;
  logic [NUM_CH-1:0] valid_w;
  logic [NUM_CH-1:0] ovr_w;
  logic [ADC_W-1:0]  data_w [NUM_CH];
  logic              unused_ok;

  assign unused_ok = ^{PADDR[1:0], PWDATA[31:NUM_CH]};

  assign access   = PSEL & PENABLE;
  assign data_idx = PADDR[7:2] - DATA_BASE[7:2];

  always_comb begin
    sel = REG_NONE;
    if (data_idx < 6'(NUM_CH))              sel = REG_DATA;
    else if (PADDR[7:2] == STATUS_OFS[7:2])  sel = REG_STATUS;
    else if (PADDR[7:2] == CTRL_OFS[7:2])    sel = REG_CTRL;
    else if (PADDR[7:2] == OVR_CLR_OFS[7:2]) sel = REG_OVR_CLR;
  end

  assign err = access & ((sel == REG_NONE) |
                         (PWRITE & ((sel == REG_DATA) | (sel == REG_STATUS))));

  assign ctrl_d  = (access && PWRITE && sel == REG_CTRL) ? PWDATA[NUM_CH-1:0] : ctrl_q;
  assign ovr_clr = (access && PWRITE && sel == REG_OVR_CLR) ? PWDATA[NUM_CH-1:0] : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) ctrl_q <= '1;
    else          ctrl_q <= ctrl_d;
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
    assign rd_clr[ch] = access & ~PWRITE & (sel == REG_DATA) & (data_idx == 6'(ch));

    adc_chan_capture #(
      .ADC_W    (ADC_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_chan (
      .clk_i     (PCLK),
      .rst_ni    (PRESETn),
      .strobe_i  (ADC_VALID[ch]),
      .sample_i  (ADC_DATA[ch*ADC_W +: ADC_W]),
      .enable_i  (ctrl_q[ch]),
      .rd_clr_i  (rd_clr[ch]),
      .ovr_clr_i (ovr_clr[ch]),
      .data_o    (data_w[ch]),
      .valid_o   (valid_w[ch]),
      .overrun_o (ovr_w[ch])
    );
  end

  // Read data reflects pre-update state; zero outside the access phase or on error.
  always_comb begin
    PRDATA = '0;
    if (access && !err) begin
      case (sel)
        REG_DATA: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (data_idx == 6'(c)) begin
              PRDATA[ADC_W-1:0] = data_w[c];
              PRDATA[VALID_BIT] = valid_w[c];
            end
          end
        end
        REG_STATUS: begin
          PRDATA[NUM_CH-1:0]        = valid_w;
          PRDATA[OVR_BASE +: NUM_CH] = ovr_w;
        end
        REG_CTRL: PRDATA[NUM_CH-1:0] = ctrl_q;
        default:  PRDATA = '0;
      endcase
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = err;

endmodule

// File: tb/tb_apb_adc_multi.sv
module tb_apb_adc_multi;
  localparam int NUM_CH   = 4;
  localparam int ADC_W    = 12;
  localparam int AVG_LOG2 = 2;
  localparam int SW       = NUM_CH * ADC_W;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          PSEL, PENABLE, PWRITE;
  logic [7:0]    PADDR;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;
  logic [SW-1:0] ADC_DATA;
  logic [NUM_CH-1:0] ADC_VALID;

  always #5 PCLK = ~PCLK;

  apb_adc_multi #(.NUM_CH(NUM_CH), .ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .ADC_DATA(ADC_DATA), .ADC_VALID(ADC_VALID)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: per-channel sample, flags, enables and averaging state.
  int unsigned m_data [NUM_CH];
  bit          m_valid[NUM_CH];
  bit          m_ovr  [NUM_CH];
  bit [NUM_CH-1:0] m_ctrl;
  int unsigned m_acc  [NUM_CH];
  int unsigned m_cnt  [NUM_CH];

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_data[c] = 0; m_valid[c] = 0; m_ovr[c] = 0; m_acc[c] = 0; m_cnt[c] = 0;
    end
    m_ctrl = '1;
  endfunction

  function automatic void model_read(input bit wr, input logic [7:0] a,
                                     output logic [31:0] d, output logic e);
    int w;
    w = int'(a[7:2]);
    d = '0;
    e = 1'b0;
    if (w < NUM_CH) begin
      if (wr) e = 1'b1;
      else d = m_data[w] | (m_valid[w] ? 32'h8000_0000 : 32'h0);
    end else if (w == 16) begin
      if (wr) e = 1'b1;
      else for (int c = 0; c < NUM_CH; c++) begin
        d[c] = m_valid[c];
        d[16+c] = m_ovr[c];
      end
    end else if (w == 17) begin
      for (int c = 0; c < NUM_CH; c++) d[c] = m_ctrl[c];
    end else if (w != 18) begin
      e = 1'b1;
    end
  endfunction

  function automatic void model_step(input bit acc, input bit wr, input logic [7:0] a,
                                     input logic [31:0] wd, input logic [NUM_CH-1:0] vld,
                                     input logic [SW-1:0] smp);
    logic [31:0] dd;
    logic        e;
    bit          ok, rd, clr, pub, set_ovr;
    int unsigned s, val;
    model_read(wr, a, dd, e);
    ok = acc && !e;
    for (int c = 0; c < NUM_CH; c++) begin
      s   = int'(smp[c*ADC_W +: ADC_W]);
      rd  = ok && !wr && (int'(a[7:2]) == c);
      clr = ok && wr && (int'(a[7:2]) == 18) && wd[c];
      pub = 0;
      val = s;
      if (vld[c] && m_ctrl[c]) begin
`ifdef ADC_AVG_EN
        m_acc[c] += s;
        m_cnt[c] += 1;
        if (m_cnt[c] == (1 << AVG_LOG2)) begin
          pub = 1;
          val = m_acc[c] / (1 << AVG_LOG2);
          m_acc[c] = 0;
          m_cnt[c] = 0;
        end
`else
        pub = 1;
`endif
      end
`ifdef ADC_AVG_EN
      if (!m_ctrl[c]) begin m_acc[c] = 0; m_cnt[c] = 0; end
`endif
      if (pub) begin
        set_ovr = m_valid[c] && !rd;
        m_data[c] = val;
        m_valid[c] = 1;
        if (set_ovr) m_ovr[c] = 1;
        else if (clr) m_ovr[c] = 0;
      end else begin
        if (rd)  m_valid[c] = 0;
        if (clr) m_ovr[c] = 0;
      end
    end
    if (ok && wr && int'(a[7:2]) == 17) m_ctrl = wd[NUM_CH-1:0];
  endfunction

  function automatic logic [SW-1:0] one_smp(input int c, input logic [ADC_W-1:0] v);
    logic [SW-1:0] r;
    r = '0;
    r[c*ADC_W +: ADC_W] = v;
    return r;
  endfunction

  // One clock: drive after posedge, check at negedge, advance model at posedge.
  task automatic drive_cycle(input bit sel, input bit en, input bit wr, input logic [7:0] a,
                             input logic [31:0] wd, input logic [NUM_CH-1:0] vld,
                             input logic [SW-1:0] smp, input string tag,
                             output logic [31:0] rd, output logic er);
    logic [31:0] ed;
    logic        ee;
    PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = a; PWDATA = wd;
    ADC_VALID = vld; ADC_DATA = smp;
    @(negedge PCLK);
    if (sel && en) model_read(wr, a, ed, ee);
    else begin ed = '0; ee = 1'b0; end
    chk($sformatf("%s a=%02h prdata", tag, a), PRDATA, ed);
    chk($sformatf("%s a=%02h pslverr", tag, a), 32'(PSLVERR), 32'(ee));
    rd = PRDATA;
    er = PSLVERR;
    @(posedge PCLK);
    model_step(sel && en, wr, a, wd, vld, smp);
    #1;
  endtask

  task automatic idle(input logic [NUM_CH-1:0] vld, input logic [SW-1:0] smp);
    logic [31:0] d;
    logic        e;
    drive_cycle(0, 0, 0, 8'h00, 32'h0, vld, smp, "idle", d, e);
  endtask

  task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                     input logic [NUM_CH-1:0] vld, input logic [SW-1:0] smp,
                     output logic [31:0] rd, output logic er);
    drive_cycle(1, 0, wr, a, wd, '0, '0, "setup", rd, er);
    drive_cycle(1, 1, wr, a, wd, vld, smp, "access", rd, er);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [63:0] rnd;
  logic [7:0]  addrs[13] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h1C, 8'h40,
                             8'h44, 8'h48, 8'h4C, 8'h80, 8'hFC, 8'h41};
  logic [NUM_CH-1:0] rv;

  initial begin
    PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    ADC_VALID = '0; ADC_DATA = '0;
    model_reset();
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("reset prdata", PRDATA, 32'h0);
    chk("reset pslverr", 32'(PSLVERR), 32'h0);
    chk("pready", 32'(PREADY), 32'h1);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // 1: reset values
    apb(0, 8'h44, 0, '0, '0, rd, er);
    chk("t1 ctrl", rd, 32'h0000_000F);
    apb(0, 8'h40, 0, '0, '0, rd, er);
    chk("t1 status", rd, 32'h0);
    chk("t1 pslverr", 32'(er), 32'h0);

    // 2: capture on ch2, read-to-clear
    idle(4'b0100, one_smp(2, 12'hABC));
    apb(0, 8'h08, 0, '0, '0, rd, er);
`ifndef ADC_AVG_EN
    chk("t2 data2 first", rd, 32'h8000_0ABC);
`endif
    apb(0, 8'h08, 0, '0, '0, rd, er);
`ifndef ADC_AVG_EN
    chk("t2 data2 second", rd, 32'h0000_0ABC);
`endif

    // 3: overrun and W1C
    idle(4'b0001, one_smp(0, 12'h111));
    idle(4'b0001, one_smp(0, 12'h222));
    apb(0, 8'h40, 0, '0, '0, rd, er);
`ifndef ADC_AVG_EN
    chk("t3 status ovr", rd, 32'h0001_0001);
`endif
    apb(1, 8'h48, 32'h1, '0, '0, rd, er);
    apb(0, 8'h40, 0, '0, '0, rd, er);
`ifndef ADC_AVG_EN
    chk("t3 status cleared", rd, 32'h0000_0001);
`endif

    // 4: capture coinciding with read of the same channel
    idle(4'b0010, one_smp(1, 12'h123));
    apb(0, 8'h04, 0, 4'b0010, one_smp(1, 12'h555), rd, er);
`ifndef ADC_AVG_EN
    chk("t4 old sample", rd, 32'h8000_0123);
`endif
    apb(0, 8'h04, 0, '0, '0, rd, er);
`ifndef ADC_AVG_EN
    chk("t4 new sample", rd, 32'h8000_0555);
`endif
    apb(0, 8'h40, 0, '0, '0, rd, er);
    chk("t4 ovr1", {31'b0, rd[17]}, 32'h0);

    // 5: disabled channel, unmapped and read-only write errors
    apb(1, 8'h44, 32'hFFFF_FFFE, '0, '0, rd, er);
    idle(4'b0001, one_smp(0, 12'h7FF));
    apb(0, 8'h00, 0, '0, '0, rd, er);
`ifndef ADC_AVG_EN
    chk("t5 data0 held", rd, 32'h8000_0222);
`endif
    apb(0, 8'h10, 0, '0, '0, rd, er);
    chk("t5 unmapped prdata", rd, 32'h0);
    chk("t5 unmapped pslverr", 32'(er), 32'h1);
    apb(1, 8'h40, 32'hFFFF_FFFF, '0, '0, rd, er);
    chk("t5 ro write pslverr", 32'(er), 32'h1);
    apb(0, 8'h44, 0, '0, '0, rd, er);
    chk("t5 ctrl masked", rd, 32'h0000_000E);
    apb(1, 8'h44, 32'hF, '0, '0, rd, er);

`ifdef ADC_AVG_EN
    // 6: averaging on ch3
    idle(4'b1000, one_smp(3, 12'd1));
    idle(4'b1000, one_smp(3, 12'd2));
    idle(4'b1000, one_smp(3, 12'd3));
    apb(0, 8'h40, 0, '0, '0, rd, er);
    chk("t6 not yet valid", {31'b0, rd[3]}, 32'h0);
    idle(4'b1000, one_smp(3, 12'd6));
    apb(0, 8'h0C, 0, '0, '0, rd, er);
    chk("t6 average", rd, 32'h8000_0003);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom(), $urandom()};
      for (int c = 0; c < NUM_CH; c++) rv[c] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 4) idle(rv, rnd[SW-1:0]);
      else apb($urandom_range(0, 3) == 0, addrs[$urandom_range(0, 12)], $urandom(),
               rv, rnd[SW-1:0], rd, er);
    end

    // Asynchronous reset mid-cycle
    #2 PRESETn = 1'b0;
    #1;
    model_reset();
    chk("async reset prdata", PRDATA, 32'h0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    apb(0, 8'h44, 0, '0, '0, rd, er);
    chk("post reset ctrl", rd, 32'h0000_000F);
    apb(0, 8'h40, 0, '0, '0, rd, er);
    chk("post reset status", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
